enemy_row_step_ctrl: RTL and testbench
======================================

Name: enemy_row_step_ctrl

Overview:
- Sequential controller that sits directly upstream of the per-row enemy move logic.
- Generates the 2-bit phase state and the enemy alive flag, and holds the registered 19-bit enemy position {x[9:0], y[8:0]}.
- Feeds the move logic, then on each movement tick latches the move logic's next-position result back into its position register.
- One instance per enemy; outputs also go to the renderer and collision logic.

Parameters:
- MOVE_PERIOD, 1_000_000, clock cycles per movement tick (minimum 2).
- PHASE_STEPS, 32, movement ticks per phase before the phase advances (minimum 1).
- INIT_X, 10'd320, horizontal position loaded on start.
- VERTICAL_POSITION, 9'd108, vertical position loaded on start.
- NONE, 19'h7FFFF, position code for absent/dead enemy.

Ports:
- i_Clk  input  1  system clock
- i_Rst_n  input  1  asynchronous active-low reset
- i_Start  input  1  level-sampled each clock; (re)spawns the enemy
- i_Pause  input  1  freezes tick/phase counters and position while high
- i_Hit  input  1  enemy struck this cycle
- i_NextPosition  input  19  next position from the move logic (combinational on o_EnemyPosition/o_PhaseState/o_EnemyState)
- o_EnemyState  output  1  1 = alive
- o_PhaseState  output  2  movement phase to the move logic
- o_EnemyPosition  output  19  registered current position
- o_Step  output  1  one-cycle pulse on each position update

Behaviour:
- Reset, asynchronous, while i_Rst_n = 0:
  - FSM = IDLE, o_EnemyState = 0, o_PhaseState = 2'b00, o_EnemyPosition = NONE, o_Step = 0.
  - Tick counter = 0, step counter = 0.
- FSM states: IDLE, RUN, DEAD.
- IDLE:
  - Outputs held at their reset values.
  - i_Start = 1 -> RUN next clock, loading position {INIT_X, VERTICAL_POSITION}, state 1, phase 00, counters 0.
- RUN, tick counter:
  - Counts 0..MOVE_PERIOD-1 while i_Pause = 0.
  - At MOVE_PERIOD-1 it wraps to 0 and that cycle is a step cycle.
- RUN, on a step cycle:
  - o_EnemyPosition <= i_NextPosition.
  - o_Step = 1 for exactly that clock (registered, appears on the cycle after the step decision).
  - Step counter increments. When it reaches PHASE_STEPS-1 it wraps to 0 and o_PhaseState advances 00->01->10->11->00 (2-bit wrap).
  - Net horizontal motion over one full 4-phase cycle is zero: right, left, left, right.
- i_Pause = 1: counters, position and phase hold; o_Step = 0. Release resumes from the held count, with no skipped or extra step.
- i_Hit = 1 in RUN -> DEAD next clock: o_EnemyState = 0, o_EnemyPosition = NONE, counters cleared, phase held.
  - i_Hit has priority over a coincident step; no o_Step is emitted that cycle.
  - i_Hit is honoured even while paused.
- DEAD: all outputs static; i_Hit ignored. i_Start -> RUN with the same load as from IDLE.
- i_Start while in RUN: immediate respawn (full reload, counters cleared). i_Start has priority over i_Hit and over a step in the same cycle.
- i_Hit in IDLE is ignored.
- Reset asserted mid-operation: all state returns to reset values asynchronously; no pulse on o_Step.
- Width rules:
  - Tick counter width is $clog2(MOVE_PERIOD); step counter width is $clog2(PHASE_STEPS), minimum 1 bit.
  - Position is never computed here; x wrap-around is owned by the move logic and passed through unchecked.

Optional Feature:
- Macro: ENEMY_SPEEDUP_EN.
- Defined:
  - The effective period register starts at MOVE_PERIOD on every start.
  - Each time phase wraps 11->00, the period halves (logical shift right by 1), floored at 2.
  - The tick counter compares against the effective period.
- Undefined: the period is the constant MOVE_PERIOD; no extra register is synthesized.

Test Plan (override MOVE_PERIOD=4, PHASE_STEPS=2, next position modelled as x+1 for phases 00/11 and x-1 for 01/10, y = 108):
- Reset low 3 cycles, then high with i_Start=0 for 20 cycles -> o_EnemyState=0, o_EnemyPosition=19'h7FFFF, o_PhaseState=00, no o_Step.
- i_Start pulse, run 16 cycles -> o_Step every 4th cycle; x sequence 321, 322 (phase 00), then 321, 320 (phase 01); o_PhaseState reaches 10 after the 4th step.
- After 2 steps assert i_Pause for 10 cycles -> x stays 322, phase 01 holds, no o_Step; on release the next step arrives exactly 4 cycles after the last pre-pause count resumes.
- i_Hit on the same cycle as a step -> next clock o_EnemyState=0, o_EnemyPosition=NONE, no o_Step; subsequent i_Hit ignored; i_Start respawns at {320,108}, phase 00.
- i_Rst_n pulled low mid-RUN at x=321 -> outputs return to reset values immediately (before the next clock edge).
- With ENEMY_SPEEDUP_EN: after the first full 4-phase cycle (8 steps) the step spacing becomes 2 cycles, and stays 2 after the next cycle (floor).

Source files
------------

// File: rtl/enemy_row_step_ctrl.sv
// enemy_row_step_ctrl
// Per-enemy sequencer that sits in front of the row move logic. It owns the
// spawn/alive/dead state, the 2-bit movement phase and the registered
// {x[9:0], y[8:0]} position. On each movement tick it takes the move
// logic's next-position result into the position register.
//
// Optional build macro ENEMY_SPEEDUP_EN: the tick period starts at
// MOVE_PERIOD on every spawn and halves (floored at 2) each time the phase
// wraps 11->00. Without the macro the period is the constant MOVE_PERIOD.
module enemy_row_step_ctrl #(
   parameter int          MOVE_PERIOD       = 1_000_000,
   parameter int          PHASE_STEPS       = 32,
   parameter logic [9:0]  INIT_X            = 10'd320,
   parameter logic [8:0]  VERTICAL_POSITION = 9'd108,
   parameter logic [18:0] NONE              = 19'h7FFFF
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   input  logic        i_Start,
   input  logic        i_Pause,
   input  logic        i_Hit,
   input  logic [18:0] i_NextPosition,
   output logic        o_EnemyState,
   output logic [1:0]  o_PhaseState,
   output logic [18:0] o_EnemyPosition,
   output logic        o_Step
);

   localparam int TICK_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
   localparam int STEP_W = (PHASE_STEPS > 1) ? $clog2(PHASE_STEPS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DEAD = 2'd2;

   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PHASE_STEPS - 1);
   localparam logic [18:0]       SPAWN_POS = {INIT_X, VERTICAL_POSITION};

   logic [1:0]        r_state;
   logic [TICK_W-1:0] r_tick;
   logic [STEP_W-1:0] r_step_cnt;
   logic [1:0]        r_phase;
   logic [18:0]       r_position;
   logic              r_step;

   logic [TICK_W-1:0] w_tick_last;
   logic              w_running;
   logic              w_step;
   logic              w_phase_wrap;

`ifdef ENEMY_SPEEDUP_EN
   localparam int PER_W = $clog2(MOVE_PERIOD + 1);

   logic [PER_W-1:0] r_period;
   logic [PER_W-1:0] w_period_half;

   assign w_period_half = r_period >> 1;
   assign w_tick_last   = TICK_W'(r_period - PER_W'(1));

   // Effective period: reload on spawn, halve (floor 2) on each 11->00 phase wrap
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_period <= PER_W'(MOVE_PERIOD);
      end else if (i_Start) begin
         r_period <= PER_W'(MOVE_PERIOD);
      end else if (w_phase_wrap && (r_phase == 2'b11) && !(r_state == S_RUN && i_Hit)) begin
         r_period <= (w_period_half < PER_W'(2)) ? PER_W'(2) : w_period_half;
      end
   end
`else
   assign w_tick_last = TICK_W'(MOVE_PERIOD - 1);
`endif

   // Step decision: a running, unpaused enemy whose tick counter has reached the period end
   always_comb begin
      w_running    = (r_state == S_RUN) && !i_Pause;
      w_step       = w_running && (r_tick == w_tick_last);
      w_phase_wrap = w_step && (r_step_cnt == STEP_LAST);
   end

   // Main FSM, counters, phase and position; priority is start > hit > step
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state    <= S_IDLE;
         r_tick     <= '0;
         r_step_cnt <= '0;
         r_phase    <= 2'b00;
         r_position <= NONE;
         r_step     <= 1'b0;
      end else begin
         // NOTE: every register here is updated with <= so all of them see the
         // pre-edge values of each other; a blocking = would let later lines
         // observe the new state and silently reorder the priority chain.
         r_step <= 1'b0;
         if (i_Start) begin
            r_state    <= S_RUN;
            r_tick     <= '0;
            r_step_cnt <= '0;
            r_phase    <= 2'b00;
            r_position <= SPAWN_POS;
         end else if ((r_state == S_RUN) && i_Hit) begin
            // Phase is deliberately left as it was when the enemy died
            r_state    <= S_DEAD;
            r_tick     <= '0;
            r_step_cnt <= '0;
            r_position <= NONE;
         end else if (w_running) begin
            if (w_step) begin
               r_tick     <= '0;
               r_position <= i_NextPosition;
               r_step     <= 1'b1;
               if (w_phase_wrap) begin
                  r_step_cnt <= '0;
                  r_phase    <= r_phase + 2'b01;
               end else begin
                  r_step_cnt <= r_step_cnt + STEP_W'(1);
               end
            end else begin
               r_tick <= r_tick + TICK_W'(1);
            end
         end
      end
   end

   assign o_EnemyState    = (r_state == S_RUN);
   assign o_PhaseState    = r_phase;
   assign o_EnemyPosition = r_position;
   assign o_Step          = r_step;

endmodule

// File: tb/tb_enemy_row_step_ctrl.sv
// tb_enemy_row_step_ctrl
// Directed bench for enemy_row_step_ctrl with MOVE_PERIOD=4, PHASE_STEPS=2.
// The move logic is stood in for by x+1 in phases 00/11 and x-1 in 01/10,
// y fixed at 108. Build with ENEMY_SPEEDUP_EN to add the speed-up sequence.
module tb_enemy_row_step_ctrl;

   localparam logic [18:0] NONE  = 19'h7FFFF;
   localparam logic [8:0]  Y_ROW = 9'd108;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        pause = 1'b0;
   logic        hit = 1'b0;
   logic [18:0] next_pos;
   logic        enemy_state;
   logic [1:0]  phase;
   logic [18:0] position;
   logic        step;

   int tests_run    = 0;
   int tests_failed = 0;

   enemy_row_step_ctrl #(
      .MOVE_PERIOD(4),
      .PHASE_STEPS(2)
   ) dut (
      .i_Clk          (clk),
      .i_Rst_n        (rst_n),
      .i_Start        (start),
      .i_Pause        (pause),
      .i_Hit          (hit),
      .i_NextPosition (next_pos),
      .o_EnemyState   (enemy_state),
      .o_PhaseState   (phase),
      .o_EnemyPosition(position),
      .o_Step         (step)
   );

   always #5 clk = ~clk;

   // Stand-in for the row move logic
   always_comb begin
      next_pos = {((phase == 2'b00) || (phase == 2'b11)) ? position[18:9] + 10'd1
                                                         : position[18:9] - 10'd1, Y_ROW};
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int steps;
      int gap;
      int exp_x[4];
      exp_x = '{321, 322, 321, 320};

      // Reset held low for three cycles
      repeat (3) cyc();
      check("rst_state", 32'(enemy_state), 32'd0);
      check("rst_pos", 32'(position), 32'(NONE));
      check("rst_phase", 32'(phase), 32'd0);
      check("rst_step", 32'(step), 32'd0);

      // Idle for 20 cycles, with a stray hit that must be ignored
      rst_n = 1'b1;
      steps = 0;
      for (int c = 0; c < 20; c++) begin
         hit = (c == 5);
         cyc();
         if (step) steps++;
      end
      hit = 1'b0;
      check("idle_steps", 32'(steps), 32'd0);
      check("idle_state", 32'(enemy_state), 32'd0);
      check("idle_pos", 32'(position), 32'(NONE));
      check("idle_phase", 32'(phase), 32'd0);

      // Spawn and run 16 cycles: one step every 4 cycles
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("spawn_state", 32'(enemy_state), 32'd1);
      check("spawn_pos", 32'(position), 32'({10'd320, Y_ROW}));
      check("spawn_phase", 32'(phase), 32'd0);
      check("spawn_step", 32'(step), 32'd0);
      steps = 0;
      for (int c = 1; c <= 16; c++) begin
         cyc();
         if (step) begin
            steps++;
            check($sformatf("run_step%0d_cycle", steps), 32'(c), 32'(steps * 4));
            if (steps <= 4)
               check($sformatf("run_step%0d_x", steps), 32'(position[18:9]), 32'(exp_x[steps-1]));
         end
      end
      check("run_step_count", 32'(steps), 32'd4);
      check("run_phase_after4", 32'(phase), 32'd2);

      // Respawn, take two steps, then pause for 10 cycles
      start = 1'b1;
      cyc();
      start = 1'b0;
      repeat (8) cyc();
      check("prepause_x", 32'(position[18:9]), 32'd322);
      check("prepause_phase", 32'(phase), 32'd1);
      pause = 1'b1;
      steps = 0;
      repeat (10) begin
         cyc();
         if (step) steps++;
      end
      check("pause_steps", 32'(steps), 32'd0);
      check("pause_x", 32'(position[18:9]), 32'd322);
      check("pause_phase", 32'(phase), 32'd1);
      pause = 1'b0;
      steps = 0;
      gap = 0;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         if (step) begin
            steps++;
            gap = c;
         end
      end
      check("resume_steps", 32'(steps), 32'd1);
      check("resume_gap", 32'(gap), 32'd4);
      check("resume_x", 32'(position[18:9]), 32'd321);

      // Hit coincident with the next step cycle (that step would also wrap the phase)
      repeat (3) cyc();
      hit = 1'b1;
      cyc();
      hit = 1'b0;
      check("hit_state", 32'(enemy_state), 32'd0);
      check("hit_pos", 32'(position), 32'(NONE));
      check("hit_step", 32'(step), 32'd0);
      check("hit_phase", 32'(phase), 32'd1);

      // Further hits while dead are ignored
      hit = 1'b1;
      repeat (2) cyc();
      hit = 1'b0;
      cyc();
      check("dead_state", 32'(enemy_state), 32'd0);
      check("dead_pos", 32'(position), 32'(NONE));

      // Respawn from DEAD
      start = 1'b1;
      cyc();
      start = 1'b0;
      check("respawn_state", 32'(enemy_state), 32'd1);
      check("respawn_pos", 32'(position), 32'({10'd320, Y_ROW}));
      check("respawn_phase", 32'(phase), 32'd0);

      // Start and hit together mid-run: start wins and counters restart
      repeat (2) cyc();
      start = 1'b1;
      hit = 1'b1;
      cyc();
      start = 1'b0;
      hit = 1'b0;
      check("start_over_hit_state", 32'(enemy_state), 32'd1);
      check("start_over_hit_pos", 32'(position), 32'({10'd320, Y_ROW}));
      gap = 0;
      for (int c = 1; c <= 4; c++) begin
         cyc();
         if (step && gap == 0) gap = c;
      end
      check("reload_gap", 32'(gap), 32'd4);
      check("reload_x", 32'(position[18:9]), 32'd321);

      // Asynchronous reset mid-run, while the step pulse is high at x=321
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_state", 32'(enemy_state), 32'd0);
      check("async_rst_pos", 32'(position), 32'(NONE));
      check("async_rst_phase", 32'(phase), 32'd0);
      check("async_rst_step", 32'(step), 32'd0);
      repeat (2) cyc();
      check("async_rst_hold_step", 32'(step), 32'd0);
      rst_n = 1'b1;
      cyc();

`ifdef ENEMY_SPEEDUP_EN
      // Speed-up: 8 steps at spacing 4, then spacing 2, still 2 after the next wrap
      begin
         int k;
         int last;
         int c;
         k = 0;
         last = 0;
         c = 0;
         start = 1'b1;
         cyc();
         start = 1'b0;
         while (k < 20 && c < 200) begin
            cyc();
            c++;
            if (step) begin
               k++;
               check($sformatf("speedup_gap%0d", k), 32'(c - last), (k <= 8) ? 32'd4 : 32'd2);
               last = c;
            end
         end
         check("speedup_step_count", 32'(k), 32'd20);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
